// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state type and default width for the bit-serial adder
package serial_add_pkg;
    localparam int SERIAL_ADD_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/halfadder.sv
// halfadder: one-bit half-adder cell
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: LSB-first bit-serial adder sequencing two shared half-adder cells
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_e state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic carry_q, carry_d, cout_q, cout_d;
    logic s1, c1, s, c2;
    halfadder u_ha1 (.a(sh_a_q[0]), .b(sh_b_q[0]), .s(s1), .c(c1));
    halfadder u_ha2 (.a(s1), .b(carry_q), .s(s), .c(c2));
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                sh_a_d  = a;
                sh_b_d  = b;
                res_d   = '0;
                carry_d = 1'b0;
                cnt_d   = '0;
            end
            RUN: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                res_d   = {s, res_q[WIDTH-1:1]};
                carry_d = c1 | c2;
                cnt_d   = cnt_q + 1'b1;
                // last bit: publish the completed word and carry on this edge
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    sum_d   = res_d;
                    cout_d  = carry_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for the bit-serial adder at WIDTH 8 and 16
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    logic start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic busy8, done8, cout8;
    logic start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, sum16;
    logic busy16, done16, cout16;
    logic [8:0] q8[$];
    logic [16:0] q16[$];
    logic [8:0] last8 = '0;
    logic [16:0] last16 = '0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (rst_n && done8) begin
        if (q8.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done8_unexpected got sum=%0h cout=%0b want no done", sum8, cout8);
        end else chk("result8", 32'({cout8, sum8}), 32'(q8.pop_front()));
        last8 = {cout8, sum8};
    end

    always @(negedge clk) if (rst_n && done16) begin
        if (q16.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done16_unexpected got sum=%0h cout=%0b want no done", sum16, cout16);
        end else chk("result16", 32'({cout16, sum16}), 32'(q16.pop_front()));
        last16 = {cout16, sum16};
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp, output int t_done);
        int n = 0;
        @(negedge clk);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        q8.push_back(exp);
        @(negedge clk);
        start8 = 1'b0;
        while (busy8 && n < 40) begin
            chk("hold8", 32'({cout8, sum8}), 32'(last8));
            n++;
            @(negedge clk);
        end
        chk("busy_len8", n, 8);
        chk("done8", 32'(done8), 1);
        t_done = cyc;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [16:0] exp, output int t_done);
        int n = 0;
        @(negedge clk);
        a16 = a;
        b16 = b;
        start16 = 1'b1;
        q16.push_back(exp);
        @(negedge clk);
        start16 = 1'b0;
        while (busy16 && n < 60) begin
            chk("hold16", 32'({cout16, sum16}), 32'(last16));
            n++;
            @(negedge clk);
        end
        chk("busy_len16", n, 16);
        chk("done16", 32'(done16), 1);
        t_done = cyc;
    endtask

    initial begin
        int t, n;
        repeat (3) @(negedge clk);
        chk("reset8", 32'({busy8, done8, cout8, sum8}), 0);
        chk("reset16", 32'({busy16, done16, cout16, sum16}), 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle8", 32'({busy8, done8, cout8, sum8}), 0);
            chk("idle16", 32'({busy16, done16, cout16, sum16}), 0);
        end
        run8(8'hA5, 8'h5A, 9'h0FF, t);
        run8(8'hFF, 8'h01, 9'h100, t);
        run8(8'h80, 8'h80, 9'h100, t);
        run8(8'h7F, 8'h01, 9'h080, t);
        // starts during RUN and DONE must be ignored
        @(negedge clk);
        a8 = 8'h03;
        b8 = 8'h04;
        start8 = 1'b1;
        q8.push_back(9'h007);
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hFF;
        b8 = 8'hFF;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("done_ignored_start", 32'(done8), 1);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) begin
            chk("idle_after_ignore", 32'({busy8, done8}), 0);
            @(negedge clk);
        end
        // abort mid-RUN with reset
        run8(8'h10, 8'h20, 9'h030, t);
        @(negedge clk);
        a8 = 8'hF0;
        b8 = 8'h20;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort8", 32'({busy8, done8, cout8, sum8}), 0);
        rst_n = 1'b1;
        last8 = '0;
        last16 = '0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle8", 32'({busy8, done8, cout8, sum8}), 0);
        end
        run8(8'h01, 8'h01, 9'h002, t);
        fork
            begin
                int tp, tn;
                logic [7:0] x, y;
                run8(8'h00, 8'h00, 9'h000, tp);
                for (int i = 0; i < 50; i++) begin
                    x = 8'($urandom);
                    y = 8'($urandom);
                    run8(x, y, 9'(x) + 9'(y), tn);
                    chk("gap8", tn - tp, 10);
                    tp = tn;
                end
            end
            begin
                int tp, tn;
                logic [15:0] x, y;
                run16(16'hFFFF, 16'h0001, 17'h10000, tp);
                for (int i = 0; i < 50; i++) begin
                    x = 16'($urandom);
                    y = 16'($urandom);
                    run16(x, y, 17'(x) + 17'(y), tn);
                    chk("gap16", tn - tp, 18);
                    tp = tn;
                end
            end
        join
        repeat (5) @(negedge clk);
        chk("pending8", q8.size(), 0);
        chk("pending16", q16.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
